// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg: opcode and field positions shared by instruction encoders and decoders
package inst_enc_pkg;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam int IMM_J_MSB = 31;
  localparam int IMM_J_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 7;
  localparam int OPC_MSB = 6;
  function automatic logic [31:0] pack_j(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    logic [31:0] w;
    w = '0;
    w[IMM_J_MSB:IMM_J_LSB] = imm;
    w[RD_MSB:RD_LSB] = rd;
    w[OPC_MSB:0] = opc;
    return w;
  endfunction
endpackage

// File: rtl/inst_j_enc_if.sv
// inst_j_enc_if: field input handshake, word output handshake and status of the J-type encoder
interface inst_j_enc_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic in_ready;
  logic [19:0] in_imm;
  logic [4:0] in_rd;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_word;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] count;
  modport slave(
    input in_valid, in_imm, in_rd, out_ready,
    output in_ready, out_valid, out_word, level, count
  );
  modport master(
    output in_valid, in_imm, in_rd, out_ready,
    input in_ready, out_valid, out_word, level, count
  );
endinterface

// File: rtl/inst_j_enc_fifo.sv
// sync_fifo: single-clock FIFO with separate occupancy counter so full/empty never alias
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/inst_j_enc.sv
// inst_j_enc: packs rd/imm into JAL-format words and queues them for a downstream consumer
module inst_j_enc
  import inst_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [6:0] OPCODE = OPC_JAL,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  inst_j_enc_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic push, pop;
  logic [31:0] word, head;
  logic [LW-1:0] level;
  // ready depends only on stored occupancy, so a full queue refuses even while draining
  assign bus.in_ready = level != LW'(DEPTH);
  assign bus.out_valid = level != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign word = pack_j(bus.in_imm, bus.in_rd, OPCODE);
  assign bus.out_word = bus.out_valid ? head : '0;
  assign bus.level = level;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(word),
    .dout(head),
    .level(level)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) bus.count <= '0;
    else if (push) bus.count <= bus.count + CNT_W'(1);
  end
endmodule
